// File: rtl/arrow_track_pkg.sv
// Shared encodings for the arrow gameplay core and the display stage: states, arrow codes, masks.
// Also carries the saturating score helper used by the judgement logic.
package arrow_track_pkg;

    localparam int ARROW_W = 5;
    localparam int STATE_W = 2;
    localparam int SCORE_W = 14;
    localparam int LFSR_W  = 16;

    typedef logic [ARROW_W-1:0] arrow_t;
    typedef logic [3:0]         btn_mask_t;
    typedef logic [SCORE_W-1:0] score_t;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_GAME  = 2'd1;
    localparam logic [STATE_W-1:0] ST_PAUSE = 2'd2;

    localparam arrow_t ARROW_UP         = 5'd10;
    localparam arrow_t ARROW_DOWN       = 5'd11;
    localparam arrow_t ARROW_LEFT       = 5'd12;
    localparam arrow_t ARROW_RIGHT      = 5'd13;
    localparam arrow_t ARROW_UP_DOWN    = 5'd14;
    localparam arrow_t ARROW_UP_LEFT    = 5'd15;
    localparam arrow_t ARROW_UP_RIGHT   = 5'd16;
    localparam arrow_t ARROW_DOWN_LEFT  = 5'd17;
    localparam arrow_t ARROW_DOWN_RIGHT = 5'd18;
    localparam arrow_t ARROW_LEFT_RIGHT = 5'd19;
    localparam arrow_t ARROW_NONE       = 5'd20;

    // Button bit order: 3 up, 2 down, 1 left, 0 right.
    localparam btn_mask_t MASK_UP    = 4'b1000;
    localparam btn_mask_t MASK_DOWN  = 4'b0100;
    localparam btn_mask_t MASK_LEFT  = 4'b0010;
    localparam btn_mask_t MASK_RIGHT = 4'b0001;
    localparam btn_mask_t MASK_NONE  = 4'b0000;

    localparam score_t            SCORE_MAX_DEF  = 14'd9999;
    localparam score_t            COMBO_BONUS_TH = 14'd10;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEF  = 16'hACE1;

    typedef enum logic [1:0] {
        JUDGE_NONE = 2'd0,
        JUDGE_HIT  = 2'd1,
        JUDGE_MISS = 2'd2
    } judge_e;

    function automatic score_t sat_add(input score_t a, input score_t b, input score_t lim);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, lim}) ? lim : sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/arrow_mask.sv
// Combinational decoder from arrow code to the set of buttons that must be pressed.
// Zero latency; unknown codes and the none code decode to an empty mask.
module arrow_mask
    import arrow_track_pkg::*;
(
    input  logic [ARROW_W-1:0] code_i,
    output logic [3:0]         mask_o
);

    always_comb begin
        mask_o = MASK_NONE;
        case (code_i)
            ARROW_UP:         mask_o = MASK_UP;
            ARROW_DOWN:       mask_o = MASK_DOWN;
            ARROW_LEFT:       mask_o = MASK_LEFT;
            ARROW_RIGHT:      mask_o = MASK_RIGHT;
            ARROW_UP_DOWN:    mask_o = MASK_UP | MASK_DOWN;
            ARROW_UP_LEFT:    mask_o = MASK_UP | MASK_LEFT;
            ARROW_UP_RIGHT:   mask_o = MASK_UP | MASK_RIGHT;
            ARROW_DOWN_LEFT:  mask_o = MASK_DOWN | MASK_LEFT;
            ARROW_DOWN_RIGHT: mask_o = MASK_DOWN | MASK_RIGHT;
            ARROW_LEFT_RIGHT: mask_o = MASK_LEFT | MASK_RIGHT;
            default:          mask_o = MASK_NONE;
        endcase
    end

endmodule

// File: rtl/arrow_track.sv
// Gameplay core: judges buttons against the target arrow on each beat and shifts in a new random arrow.
// Outputs update one clock after the beat is seen; no backpressure, all outputs registered.
module arrow_track
    import arrow_track_pkg::*;
#(
    parameter int                  NUM_ARROWS_BITS = ARROW_W - 1,
    parameter int                  STATE_BITS      = STATE_W - 1,
    parameter logic [STATE_BITS:0] STATE_IDLE      = ST_IDLE,
    parameter logic [STATE_BITS:0] STATE_GAME      = ST_GAME,
    parameter logic [STATE_BITS:0] STATE_PAUSE     = ST_PAUSE,
    parameter logic [LFSR_W-1:0]   LFSR_SEED       = LFSR_SEED_DEF,
    parameter score_t              SCORE_MAX       = SCORE_MAX_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     metronome_clk,
    input  logic [STATE_BITS:0]      state,
    input  logic [3:0]               btn,
    output logic [NUM_ARROWS_BITS:0] cur_arrow0,
    output logic [NUM_ARROWS_BITS:0] cur_arrow1,
    output logic [NUM_ARROWS_BITS:0] cur_arrow2,
    output logic [NUM_ARROWS_BITS:0] cur_arrow3,
    output logic [SCORE_W-1:0]       score,
    output logic [SCORE_W-1:0]       comboCount,
    output logic                     hit,
    output logic                     miss
);

    localparam int            AW         = NUM_ARROWS_BITS + 1;
    localparam logic [AW-1:0] CODE_NONE  = AW'(ARROW_NONE);
    localparam logic [AW-1:0] CODE_FIRST = AW'(ARROW_UP);

    logic                   met_q, met_prev_q;
    logic [3:0]             btn_q;
    logic [3:0]             pressed_q, pressed_d;
    logic [LFSR_W-1:0]      lfsr_q, lfsr_d;
    logic [3:0][AW-1:0]     arr_q, arr_d;
    score_t                 score_q, score_d;
    score_t                 combo_q, combo_d;
    logic                   hit_q, hit_d;
    logic                   miss_q, miss_d;

    logic                   beat;
    logic [3:0]             btn_rise;
    logic [3:0]             req_mask;
    logic                   lfsr_fb;
    logic [3:0]             lfsr_nib;
    logic [AW-1:0]          new_arrow;
    score_t                 bonus_inc;
    judge_e                 judge;

    assign beat     = met_q & ~met_prev_q;
    assign btn_rise = btn & ~btn_q;

    // Slot 3 is the arrow being judged, slot 0 the newest arrival.
    arrow_mask u_arrow_mask (
        .code_i (ARROW_W'(arr_q[3])),
        .mask_o (req_mask)
    );

    assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign lfsr_nib  = lfsr_q[3:0];
    assign new_arrow = (lfsr_nib < 4'd11) ? CODE_FIRST + AW'(lfsr_nib) : CODE_NONE;
    assign bonus_inc = (combo_q >= COMBO_BONUS_TH) ? score_t'(2) : score_t'(1);

    // An empty target with no presses is neutral; any disagreement is a miss.
    always_comb begin
        judge = JUDGE_NONE;
        if (pressed_q != req_mask) begin
            judge = JUDGE_MISS;
        end else if (req_mask != MASK_NONE) begin
            judge = JUDGE_HIT;
        end
    end

    always_comb begin
        arr_d     = arr_q;
        score_d   = score_q;
        combo_d   = combo_q;
        lfsr_d    = lfsr_q;
        pressed_d = pressed_q;
        hit_d     = 1'b0;
        miss_d    = 1'b0;

        if (state == STATE_GAME) begin
            if (beat) begin
                case (judge)
                    JUDGE_HIT: begin
                        score_d = sat_add(score_q, bonus_inc, SCORE_MAX);
                        combo_d = sat_add(combo_q, score_t'(1), SCORE_MAX);
                        hit_d   = 1'b1;
                    end
                    JUDGE_MISS: begin
                        combo_d = '0;
                        miss_d  = 1'b1;
                    end
                    default: ;
                endcase
                arr_d     = {arr_q[2], arr_q[1], arr_q[0], new_arrow};
                lfsr_d    = {lfsr_q[LFSR_W-2:0], lfsr_fb};
                // A rise landing on the beat cycle belongs to the window that starts now.
                pressed_d = btn_rise;
            end else begin
                pressed_d = pressed_q | btn_rise;
            end
        end else if (state == STATE_PAUSE) begin
            pressed_d = '0;
        end else begin
            arr_d     = {4{CODE_NONE}};
            score_d   = '0;
            combo_d   = '0;
            lfsr_d    = LFSR_SEED;
            pressed_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            met_q      <= 1'b0;
            met_prev_q <= 1'b0;
            btn_q      <= '0;
            pressed_q  <= '0;
            lfsr_q     <= LFSR_SEED;
            arr_q      <= {4{CODE_NONE}};
            score_q    <= '0;
            combo_q    <= '0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
        end else begin
            met_q      <= metronome_clk;
            met_prev_q <= met_q;
            btn_q      <= btn;
            pressed_q  <= pressed_d;
            lfsr_q     <= lfsr_d;
            arr_q      <= arr_d;
            score_q    <= score_d;
            combo_q    <= combo_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
        end
    end

    assign cur_arrow0 = arr_q[0];
    assign cur_arrow1 = arr_q[1];
    assign cur_arrow2 = arr_q[2];
    assign cur_arrow3 = arr_q[3];
    assign score      = score_q;
    assign comboCount = combo_q;
    assign hit        = hit_q;
    assign miss       = miss_q;

    a_hit_miss_excl: assert property (@(posedge clk) disable iff (!rst_n) !(hit_q && miss_q));
    a_score_bound:   assert property (@(posedge clk) disable iff (!rst_n)
                                      (score_q <= SCORE_MAX) && (combo_q <= SCORE_MAX));
    a_lfsr_live:     assert property (@(posedge clk) disable iff (!rst_n) lfsr_q != '0);

endmodule

// File: tb/tb_arrow_track.sv
module tb_arrow_track;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        metronome_clk = 1'b0;
    logic [1:0]  state = 2'd0;
    logic [3:0]  btn = 4'b0;
    logic [4:0]  cur_arrow0, cur_arrow1, cur_arrow2, cur_arrow3;
    logic [13:0] score, comboCount;
    logic        hit, miss;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    arrow_track #(.SCORE_MAX(14'd31)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .metronome_clk (metronome_clk),
        .state         (state),
        .btn           (btn),
        .cur_arrow0    (cur_arrow0),
        .cur_arrow1    (cur_arrow1),
        .cur_arrow2    (cur_arrow2),
        .cur_arrow3    (cur_arrow3),
        .score         (score),
        .comboCount    (comboCount),
        .hit           (hit),
        .miss          (miss)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic press(input logic [3:0] m);
        @(negedge clk); btn = m;
        @(negedge clk); btn = 4'b0;
    endtask

    // Returns at the negedge after the update edge, while hit/miss pulses are visible.
    task automatic beat(input logic [3:0] on_beat);
        @(negedge clk); metronome_clk = 1'b1;
        @(negedge clk); metronome_clk = 1'b0; btn = on_beat;
        @(negedge clk); btn = 4'b0;
    endtask

    function automatic logic [3:0] ref_mask(input int code);
        case (code)
            10: return 4'b1000;  11: return 4'b0100;
            12: return 4'b0010;  13: return 4'b0001;
            14: return 4'b1100;  15: return 4'b1010;
            16: return 4'b1001;  17: return 4'b0110;
            18: return 4'b0101;  19: return 4'b0011;
            default: return 4'b0000;
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] m_lfsr;
        int          win [4];
        int          m_sc, m_cb, hits, nb, tgt, nw;
        logic [3:0]  m;

        repeat (2) @(negedge clk);
        check_val("rst_cur0", cur_arrow0, 20);
        check_val("rst_cur3", cur_arrow3, 20);
        check_val("rst_score", score, 0);
        check_val("rst_combo", comboCount, 0);
        check_val("rst_hit", hit, 0);
        check_val("rst_miss", miss, 0);

        rst_n = 1'b1;
        @(negedge clk); state = 2'd1;
        @(negedge clk);

        // Arrows by beat from seed: 11,13,17,20,20,20,19,12,14
        beat(4'b0);
        check_val("b1_cur0", cur_arrow0, 11);
        check_val("b1_cur1", cur_arrow1, 20);
        check_val("b1_cur3", cur_arrow3, 20);
        check_val("b1_hit", hit, 0);
        check_val("b1_miss", miss, 0);
        beat(4'b0); beat(4'b0); beat(4'b0);
        check_val("b4_cur3", cur_arrow3, 11);
        check_val("b4_cur2", cur_arrow2, 13);
        check_val("b4_cur1", cur_arrow1, 17);
        check_val("b4_cur0", cur_arrow0, 20);

        beat(4'b0);
        check_val("b5_miss", miss, 1);
        check_val("b5_hit", hit, 0);
        check_val("b5_combo", comboCount, 0);
        check_val("b5_cur3", cur_arrow3, 13);

        press(4'b0001); beat(4'b0);
        check_val("b6_hit", hit, 1);
        check_val("b6_score", score, 1);
        check_val("b6_combo", comboCount, 1);
        @(negedge clk);
        check_val("b6_hit_pulse", hit, 0);

        press(4'b0110); beat(4'b0);
        check_val("b7_hit", hit, 1);
        check_val("b7_score", score, 2);
        check_val("b7_combo", comboCount, 2);

        beat(4'b0);
        check_val("b8_neutral_hit", hit, 0);
        check_val("b8_neutral_miss", miss, 0);
        check_val("b8_combo", comboCount, 2);

        state = 2'd2;
        repeat (3) begin
            @(negedge clk); metronome_clk = 1'b1;
            repeat (2) @(negedge clk);
            metronome_clk = 1'b0;
            @(negedge clk);
        end
        press(4'b1000);
        check_val("pause_cur0", cur_arrow0, 12);
        check_val("pause_cur1", cur_arrow1, 19);
        check_val("pause_cur3", cur_arrow3, 20);
        check_val("pause_score", score, 2);
        check_val("pause_combo", comboCount, 2);
        check_val("pause_miss", miss, 0);

        @(negedge clk); metronome_clk = 1'b1;
        repeat (3) @(negedge clk);
        state = 2'd1;
        repeat (3) @(negedge clk);
        check_val("resume_no_beat_cur0", cur_arrow0, 12);
        check_val("resume_no_beat_miss", miss, 0);
        metronome_clk = 1'b0;
        @(negedge clk);

        // Left rises on the beat cycle: not judged now, carried into the next window.
        beat(4'b0010);
        check_val("b9_cur0", cur_arrow0, 14);
        check_val("b9_onbeat_miss", miss, 0);
        check_val("b9_combo", comboCount, 2);
        beat(4'b0010);
        check_val("b10_carry_miss", miss, 1);
        check_val("b10_combo", comboCount, 0);
        press(4'b0001); beat(4'b0);
        check_val("b11_hit", hit, 1);
        check_val("b11_score", score, 3);
        press(4'b0010); beat(4'b0);
        check_val("b12_score", score, 4);
        press(4'b1100); beat(4'b0);
        check_val("b13_hit", hit, 1);
        check_val("b13_score", score, 5);
        check_val("b13_combo", comboCount, 3);

        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        check_val("arst_score", score, 0);
        check_val("arst_combo", comboCount, 0);
        check_val("arst_cur2", cur_arrow2, 20);
        check_val("arst_cur0", cur_arrow0, 20);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        beat(4'b0);
        check_val("replay_cur0", cur_arrow0, 11);
        repeat (11) beat(4'b0);
        press(4'b1000); beat(4'b0);
        check_val("b13_uponly_miss", miss, 1);
        check_val("b13_uponly_hit", hit, 0);

        state = 2'd0;
        repeat (2) @(negedge clk);
        check_val("idle_cur0", cur_arrow0, 20);
        check_val("idle_cur1", cur_arrow1, 20);
        state = 2'd1;
        @(negedge clk);

        m_lfsr = 16'hACE1;
        for (int i = 0; i < 4; i++) win[i] = 20;
        m_sc = 0; m_cb = 0; hits = 0; nb = 0;
        while (hits < 34 && nb < 200) begin
            tgt = win[3];
            m   = ref_mask(tgt);
            press(m); beat(4'b0);
            nb++;
            if (m != 4'b0) begin
                m_sc = m_sc + ((m_cb >= 10) ? 2 : 1);
                if (m_sc > 31) m_sc = 31;
                m_cb = (m_cb >= 31) ? 31 : m_cb + 1;
                hits++;
            end
            nw = (m_lfsr[3:0] < 4'd11) ? 10 + int'(m_lfsr[3:0]) : 20;
            win[3] = win[2]; win[2] = win[1]; win[1] = win[0]; win[0] = nw;
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            check_val("run_hit", hit, (m != 4'b0) ? 1 : 0);
            check_val("run_score", score, m_sc);
            check_val("run_combo", comboCount, m_cb);
            check_val("run_cur0", cur_arrow0, nw);
        end
        check_val("sat_budget", (hits >= 34) ? 1 : 0, 1);
        check_val("sat_score", score, 31);
        check_val("sat_combo", comboCount, 31);

        state = 2'd3;
        repeat (2) @(negedge clk);
        check_val("undef_score", score, 0);
        check_val("undef_combo", comboCount, 0);
        check_val("undef_cur3", cur_arrow3, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/arrow_track.md
# arrow_track

Gameplay core that produces the four-arrow lookahead window and the score/combo counters consumed by the seven-segment display stage. On each metronome beat in the game state it judges the player's buttons against the target arrow, updates score and combo, and shifts a new pseudo-random arrow into the window. The display stage samples `cur_arrow0..3`, `score` and `comboCount` directly from this block.

## Interface
- `NUM_ARROWS_BITS`, default 4: arrow code width minus 1. Codes 10..20 are arrows; 20 means none.
- `STATE_BITS`, default 1: state width minus 1.
- `STATE_IDLE`=0, `STATE_GAME`=1, `STATE_PAUSE`=2: game-state encodings.
- `LFSR_SEED`, default 16'hACE1: LFSR reset and reload value. Must be nonzero.
- `SCORE_MAX`, default 9999: saturation limit for `score` and `comboCount`.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `metronome_clk` in 1: beat square wave, generated synchronously in the `clk` domain.
- `state` in STATE_BITS+1: current game state.
- `btn` in 4: debounced buttons, level-sensitive. Bit 3 up, bit 2 down, bit 1 left, bit 0 right.
- `cur_arrow0..3` out NUM_ARROWS_BITS+1 each: lookahead window. `cur_arrow3` is the target; `cur_arrow0` is the newest.
- `score` out 14: accumulated score.
- `comboCount` out 14: consecutive hits.
- `hit`, `miss` out 1 each: one-cycle judgement pulses.

## Operation
- **Edge detection**
  - Beat detect: `met_q` is `metronome_clk` registered. `beat = metronome_clk_q & ~met_q_prev`.
  - Beat is one cycle per rising edge of `metronome_clk`.
  - Button rise: `btn_rise = btn & ~btn_q`.
- **Press capture:** `pressed |= btn_rise` every cycle in GAME.
- **Arrow-to-mask mapping** (`req` = mask of `cur_arrow3`):
  - 10 → 1000, 11 → 0100, 12 → 0010, 13 → 0001.
  - 14 → 1100, 15 → 1010, 16 → 1001, 17 → 0110, 18 → 0101, 19 → 0011.
  - 20 → 0000. Any other code → 0000.
- **STATE_GAME, on a beat cycle:**
  - Judge `pressed` against `req`:
    - Hit: `req != 0` and `pressed == req`. Add 2 to `score` if `comboCount >= 10`, else add 1. `comboCount` += 1. Pulse `hit`.
    - Miss: `pressed != req`. `comboCount` ← 0. Pulse `miss`. `score` unchanged.
    - Neutral: `req == 0` and `pressed == 0`. No change, no pulse.
  - Saturation: `score` and `comboCount` saturate at SCORE_MAX and never wrap.
  - Shift: `cur_arrow3 ← cur_arrow2`, `cur_arrow2 ← cur_arrow1`, `cur_arrow1 ← cur_arrow0`.
  - New arrow: `cur_arrow0 ← (lfsr[3:0] < 11) ? 10 + lfsr[3:0] : 20`.
  - LFSR then advances. It is a 16-bit Fibonacci LFSR with taps 16,14,13,11, shifting left with feedback into bit 0.
  - `pressed` is cleared. A `btn_rise` on the beat cycle itself is captured into the new window.
- **STATE_PAUSE:** beats ignored; arrows, score, combo and LFSR held; `pressed` held at 0.
- **STATE_IDLE or any undefined state:** arrows ← 20, score and combo ← 0, LFSR ← LFSR_SEED, `pressed` ← 0.
- **Reset values:** all `cur_arrow*` = 20; `score` = `comboCount` = 0; `hit` = `miss` = 0; LFSR = LFSR_SEED; all edge and capture flops = 0.

## Timing
- **Beat latency:** `cur_arrow*`, `score`, `comboCount`, `hit` and `miss` update on clock edge k+1. Edge k is the first edge that samples `metronome_clk` high.
  - Outputs are therefore stable before any downstream two-stage edge detector samples them at edge k+2.
- **State change:** takes effect on the first edge that samples the new `state`. A beat coinciding with the transition edge is judged under the old `state`.
- **Pause resume:** no beat is synthesised on resume; the next real rising edge of `metronome_clk` is the next beat.
- **Async reset:** an `rst_n` assertion mid-game clears outputs immediately, without waiting for a clock. Release is synchronous to `clk`.
- **Output registration:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- **Shared package / include:**
  - STATE_* encodings, arrow codes 10..20, ARROW_NONE=20.
  - Mask constants.
  - SCORE_MAX and the combo-bonus threshold of 10.
  - The display stage uses the same include.
- **Sub-module `arrow_mask`:** combinational code-to-mask decoder. It is reused by any later per-button LED feedback.
- **Inline logic:** the LFSR stays inline.

## Test plan
- Reset, then `state`=GAME and one beat → `cur_arrow0`=11 (lfsr[3:0]=1), `cur_arrow1..3`=20, no hit or miss.
- Beat pipeline: after 4 beats with no presses → first arrow appears on `cur_arrow3`. On beat 5 with `cur_arrow3`=11 and no press → `miss`=1, `comboCount`=0.
- Target `cur_arrow3`=14: press up and down within the window → next beat gives `hit`=1, `score`+1, `comboCount`+1. Pressing up only gives `miss`.
- Bonus and saturation: preload `comboCount`=10, then hit → `score` +2. Force `score`=9998 with bonus hit → `score`=9999, then stays 9999.
- PAUSE: 3 metronome edges in PAUSE → all outputs unchanged. Return to GAME → first update only on the next real edge.
- Boundaries: `rst_n` low mid-window → outputs reset asynchronously. Button rise on the beat cycle → counted in the following window, not the current one.
